// File: rtl/pll_cfg_pkg.sv
// Shared definitions for the PLL reconfiguration writer and the clock-select
// logic that keeps preset tables of PLL settings.
package pll_cfg_pkg;

    localparam logic [5:0] PLL_REG_MODE  = 6'd0;
    localparam logic [5:0] PLL_REG_START = 6'd2;
    localparam logic [5:0] PLL_REG_N     = 6'd3;
    localparam logic [5:0] PLL_REG_M     = 6'd4;
    localparam logic [5:0] PLL_REG_C     = 6'd5;
    localparam logic [5:0] PLL_REG_K     = 6'd7;

    typedef enum logic [3:0] {
        IDLE,
        WR_MODE,
        WR_N,
        WR_M,
        WR_K,
        WR_C0,
        WR_START,
        WAIT_UNLOCK,
        WAIT_LOCK
    } pll_state_e;

    // Counter words: [17] bypass, [16] odd, [15:8] high count, [7:0] low count.
    typedef struct packed {
        logic [17:0] n;
        logic [17:0] m;
        logic [31:0] k;
        logic [17:0] c0;
    } pll_cfg_t;

    function automatic logic [31:0] cnt_word(input logic [17:0] w);
        return {14'b0, w};
    endfunction

    // Output counter words carry the counter select in [22:18].
    function automatic logic [31:0] c_word(input logic [4:0] sel, input logic [17:0] w);
        return {9'b0, sel, w};
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the PLL locked flag into the management clock domain.
module pll_lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic locked,
    output logic lk_s
);

    logic meta_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_p0 <= 1'b0;
            lk_s    <= 1'b0;
        end else begin
            meta_p0 <= locked;
            lk_s    <= meta_p0;
        end
    end

endmodule

// File: rtl/pll_cfg_writer.sv
// Avalon-MM initiator that writes N, M, K and C0 into the PLL reconfig core,
// starts reconfiguration and waits for lock to return.
module pll_cfg_writer
    import pll_cfg_pkg::*;
#(
    parameter int unsigned LOCK_TIMEOUT = 1_000_000,
    parameter int unsigned UNLOCK_WAIT  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_req,
    input  logic [17:0] cfg_n,
    input  logic [17:0] cfg_m,
    input  logic [31:0] cfg_k,
    input  logic [17:0] cfg_c0,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked
);

    localparam logic [31:0] UNLOCK_LAST = 32'(UNLOCK_WAIT - 1);
    localparam logic [31:0] LOCK_LAST   = 32'(LOCK_TIMEOUT - 1);

    pll_state_e  state;
    logic [31:0] timer;
    pll_cfg_t    cfg_q;
    logic        lk_s;
    logic        accept;

    pll_lock_sync u_lock_sync (
        .clk    (clk),
        .rst    (rst),
        .locked (pll_locked),
        .lk_s   (lk_s)
    );

    // A request landing in the done/error cycle is dropped so the requester
    // sees a clean completion before it can start another sequence.
    assign accept = (state == IDLE) && cfg_req && !done && !error;

    always_ff @(posedge clk) begin
        if (accept) begin
            cfg_q.n  <= cfg_n;
            cfg_q.m  <= cfg_m;
            cfg_q.k  <= cfg_k;
            cfg_q.c0 <= cfg_c0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            timer          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            mgmt_write     <= 1'b0;
            mgmt_address   <= '0;
            mgmt_writedata <= '0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state          <= WR_MODE;
                        busy           <= 1'b1;
                        mgmt_write     <= 1'b1;
                        mgmt_address   <= PLL_REG_MODE;
                        mgmt_writedata <= '0;
                    end
                end
                WR_MODE: begin
                    if (!mgmt_waitrequest) begin
                        state          <= WR_N;
                        mgmt_address   <= PLL_REG_N;
                        mgmt_writedata <= cnt_word(cfg_q.n);
                    end
                end
                WR_N: begin
                    if (!mgmt_waitrequest) begin
                        state          <= WR_M;
                        mgmt_address   <= PLL_REG_M;
                        mgmt_writedata <= cnt_word(cfg_q.m);
                    end
                end
                WR_M: begin
                    if (!mgmt_waitrequest) begin
                        state          <= WR_K;
                        mgmt_address   <= PLL_REG_K;
                        mgmt_writedata <= cfg_q.k;
                    end
                end
                WR_K: begin
                    if (!mgmt_waitrequest) begin
                        state          <= WR_C0;
                        mgmt_address   <= PLL_REG_C;
                        mgmt_writedata <= c_word(5'd0, cfg_q.c0);
                    end
                end
                WR_C0: begin
                    if (!mgmt_waitrequest) begin
                        state          <= WR_START;
                        mgmt_address   <= PLL_REG_START;
                        mgmt_writedata <= '0;
                    end
                end
                WR_START: begin
                    if (!mgmt_waitrequest) begin
                        state      <= WAIT_UNLOCK;
                        mgmt_write <= 1'b0;
                        timer      <= '0;
                    end
                end
                // Lock may never visibly drop if the new setting is close to the
                // old one, so give up waiting for the drop after a short window.
                WAIT_UNLOCK: begin
                    if (!lk_s || timer == UNLOCK_LAST) begin
                        state <= WAIT_LOCK;
                        timer <= '0;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                WAIT_LOCK: begin
                    if (lk_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (timer == LOCK_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    mgmt_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_cfg_writer.sv
// Bench for pll_cfg_writer: two instances share stimulus, one with a long lock
// timeout and one with LOCK_TIMEOUT=100 for the stuck-unlocked case.
module tb_pll_cfg_writer;
    import pll_cfg_pkg::*;

    localparam int UW   = 64;
    localparam int LT_A = 1000;
    localparam int LT_B = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_req = 1'b0;
    logic [17:0] cfg_n = '0;
    logic [17:0] cfg_m = '0;
    logic [31:0] cfg_k = '0;
    logic [17:0] cfg_c0 = '0;
    logic        waitrequest = 1'b0;
    logic        pll_locked = 1'b1;

    logic        a_busy, a_done, a_error, a_write;
    logic [5:0]  a_addr;
    logic [31:0] a_wdata;
    logic        b_busy, b_done, b_error, b_write;
    logic [5:0]  b_addr;
    logic [31:0] b_wdata;

    int total = 0;
    int bad = 0;

    logic [37:0] wq_a[$];
    logic [37:0] exp_w[6];

    always #5 clk = ~clk;

    pll_cfg_writer #(.LOCK_TIMEOUT(LT_A), .UNLOCK_WAIT(UW)) dut_a (
        .clk(clk), .rst(rst), .cfg_req(cfg_req),
        .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_c0(cfg_c0),
        .busy(a_busy), .done(a_done), .error(a_error),
        .mgmt_address(a_addr), .mgmt_write(a_write), .mgmt_writedata(a_wdata),
        .mgmt_waitrequest(waitrequest), .pll_locked(pll_locked)
    );

    pll_cfg_writer #(.LOCK_TIMEOUT(LT_B), .UNLOCK_WAIT(UW)) dut_b (
        .clk(clk), .rst(rst), .cfg_req(cfg_req),
        .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_c0(cfg_c0),
        .busy(b_busy), .done(b_done), .error(b_error),
        .mgmt_address(b_addr), .mgmt_write(b_write), .mgmt_writedata(b_wdata),
        .mgmt_waitrequest(waitrequest), .pll_locked(pll_locked)
    );

    // Every write the reconfig core actually accepts.
    always @(posedge clk) begin
        if (a_write && !waitrequest) wq_a.push_back({a_addr, a_wdata});
    end

    function automatic pll_cfg_t rand_cfg();
        pll_cfg_t c;
        c.n  = 18'($urandom);
        c.m  = 18'($urandom);
        c.k  = $urandom;
        c.c0 = 18'($urandom);
        return c;
    endfunction

    // Reference write list: {address, data} in the order the PLL must see them.
    task automatic set_expected(input pll_cfg_t c);
        exp_w[0] = {6'd0, 32'd0};
        exp_w[1] = {6'd3, 14'd0, c.n};
        exp_w[2] = {6'd4, 14'd0, c.m};
        exp_w[3] = {6'd7, c.k};
        exp_w[4] = {6'd5, 9'd0, 5'd0, c.c0};
        exp_w[5] = {6'd2, 32'd0};
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        cfg_req = 1'b0;
        waitrequest = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Returns on the negedge right after the accepting edge; inputs are then scrambled.
    task automatic issue_req(input pll_cfg_t c);
        @(negedge clk);
        cfg_n = c.n; cfg_m = c.m; cfg_k = c.k; cfg_c0 = c.c0;
        cfg_req = 1'b1;
        @(negedge clk);
        cfg_req = 1'b0;
        cfg_n = 18'($urandom); cfg_m = 18'($urandom);
        cfg_k = $urandom;      cfg_c0 = 18'($urandom);
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", a_busy); end
        total++; if (a_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", a_done); end
        total++; if (a_error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", a_error); end
        total++; if (a_write !== 1'b0) begin bad++; $display("FAIL reset_write: got %b want 0", a_write); end
        total++; if (a_addr !== 6'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", a_addr); end
        total++; if (a_wdata !== 32'd0) begin bad++; $display("FAIL reset_wdata: got %h want 0", a_wdata); end
    endtask

    task automatic test_basic();
        pll_cfg_t c;
        int base, k, done_k;
        logic busy_before;
        c.n = 18'h20000; c.m = 18'h00808; c.k = 32'h8000_0000; c.c0 = 18'h00404;
        set_expected(c);
        pll_locked = 1'b1;
        waitrequest = 1'b0;
        base = wq_a.size();
        issue_req(c);
        total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL busy_rise: got %b want 1", a_busy); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (a_write !== 1'b1 || {a_addr, a_wdata} !== exp_w[i]) begin
                bad++;
                $display("FAIL basic_write%0d: got wr=%b addr=%0d data=%h want wr=1 addr=%0d data=%h",
                         i, a_write, a_addr, a_wdata, exp_w[i][37:32], exp_w[i][31:0]);
            end
            @(negedge clk);
        end
        total++; if (a_write !== 1'b0) begin bad++; $display("FAIL write_drop: got %b want 0", a_write); end
        // Lock never drops: UW cycles of unlock wait, one FSM cycle to see lock.
        k = 1; done_k = -1; busy_before = 1'b0;
        while (k < 300 && done_k < 0) begin
            @(negedge clk);
            k++;
            if (a_done === 1'b1) done_k = k; else busy_before = a_busy;
        end
        total++; if (done_k != UW + 2) begin bad++; $display("FAIL unlock_skip_done: got cycle %0d want %0d", done_k, UW + 2); end
        total++; if (a_busy !== 1'b0 || busy_before !== 1'b1) begin bad++; $display("FAIL busy_fall: got busy=%b before=%b want 0/1", a_busy, busy_before); end
        total++; if (a_error !== 1'b0) begin bad++; $display("FAIL basic_error: got %b want 0", a_error); end
        @(negedge clk);
        total++; if (a_done !== 1'b0) begin bad++; $display("FAIL done_pulse: got %b want 0", a_done); end
        total++; if (wq_a.size() != base + 6) begin bad++; $display("FAIL basic_count: got %0d want 6", wq_a.size() - base); end
        for (int i = 0; i < 6; i++) begin
            if (wq_a.size() > base + i) begin
                total++;
                if (wq_a[base + i] !== exp_w[i]) begin bad++; $display("FAIL basic_accept%0d: got %h want %h", i, wq_a[base + i], exp_w[i]); end
            end
        end
    endtask

    task automatic test_stall();
        pll_cfg_t c;
        int base, mcyc;
        c = rand_cfg();
        set_expected(c);
        pll_locked = 1'b1;
        base = wq_a.size();
        mcyc = 0;
        issue_req(c);
        for (int it = 0; it < 200 && a_done !== 1'b1; it++) begin
            cfg_req = (a_write && a_addr == 6'd3);
            if (a_write && a_addr == 6'd4) begin
                mcyc++;
                total++;
                if (a_wdata !== {14'd0, c.m}) begin bad++; $display("FAIL stall_m_data: got %h want %h", a_wdata, {14'd0, c.m}); end
                waitrequest = (mcyc <= 3);
            end else begin
                waitrequest = 1'b0;
            end
            @(negedge clk);
        end
        cfg_req = 1'b0;
        waitrequest = 1'b0;
        total++; if (a_done !== 1'b1) begin bad++; $display("FAIL stall_done: got %b want 1", a_done); end
        total++; if (mcyc != 4) begin bad++; $display("FAIL stall_m_hold: got %0d cycles want 4", mcyc); end
        total++; if (wq_a.size() != base + 6) begin bad++; $display("FAIL stall_count: got %0d want 6", wq_a.size() - base); end
        for (int i = 0; i < 6; i++) begin
            if (wq_a.size() > base + i) begin
                total++;
                if (wq_a[base + i] !== exp_w[i]) begin bad++; $display("FAIL stall_accept%0d: got %h want %h", i, wq_a[base + i], exp_w[i]); end
            end
        end
        @(negedge clk);
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL busy_req_ignored: got %b want 0", a_busy); end
    endtask

    task automatic test_random_stall();
        pll_cfg_t c;
        int base, n;
        for (int it = 0; it < 4; it++) begin
            c = rand_cfg();
            set_expected(c);
            pll_locked = 1'b1;
            base = wq_a.size();
            issue_req(c);
            n = 0;
            while (n < 400 && a_done !== 1'b1) begin
                waitrequest = 1'($urandom_range(0, 1));
                @(negedge clk);
                n++;
            end
            waitrequest = 1'b0;
            total++; if (a_done !== 1'b1 || a_error !== 1'b0) begin bad++; $display("FAIL rnd%0d_done: got done=%b error=%b want 1/0", it, a_done, a_error); end
            total++; if (wq_a.size() != base + 6) begin bad++; $display("FAIL rnd%0d_count: got %0d want 6", it, wq_a.size() - base); end
            for (int i = 0; i < 6; i++) begin
                if (wq_a.size() > base + i) begin
                    total++;
                    if (wq_a[base + i] !== exp_w[i]) begin bad++; $display("FAIL rnd%0d_accept%0d: got %h want %h", it, i, wq_a[base + i], exp_w[i]); end
                end
            end
        end
    endtask

    task automatic test_lock_drop();
        pll_cfg_t c;
        int n, k, done_k;
        logic busy_before, err_seen;
        c = rand_cfg();
        pll_locked = 1'b1;
        waitrequest = 1'b0;
        issue_req(c);
        n = 0;
        while (n < 20 && !(a_write === 1'b1 && a_addr == 6'd2)) begin @(negedge clk); n++; end
        total++; if (n >= 20) begin bad++; $display("FAIL drop_start_seen: got timeout want START write"); end
        // k counts cycles after the START write is taken; lock is driven from the PLL side.
        k = 0; done_k = -1; busy_before = 1'b0; err_seen = 1'b0;
        while (k < 400 && done_k < 0) begin
            @(negedge clk);
            k++;
            if (a_error === 1'b1) err_seen = 1'b1;
            if (a_done === 1'b1) done_k = k;
            else begin
                busy_before = a_busy;
                if (k == 10) pll_locked = 1'b0;
                if (k == 210) pll_locked = 1'b1;
            end
        end
        total++; if (done_k != 213) begin bad++; $display("FAIL relock_done: got cycle %0d want 213", done_k); end
        total++; if (a_busy !== 1'b0 || busy_before !== 1'b1) begin bad++; $display("FAIL relock_busy: got busy=%b before=%b want 0/1", a_busy, busy_before); end
        total++; if (err_seen !== 1'b0 || a_error !== 1'b0) begin bad++; $display("FAIL relock_error: got %b want 0", err_seen | a_error); end
        cfg_req = 1'b1;
        @(negedge clk);
        cfg_req = 1'b0;
        total++; if (a_busy !== 1'b0 || a_write !== 1'b0) begin bad++; $display("FAIL req_in_done_cycle: got busy=%b write=%b want 0/0", a_busy, a_write); end
    endtask

    task automatic test_lock_timeout();
        pll_cfg_t c;
        int n, k, err_k;
        logic busy_before, done_seen;
        apply_reset();
        pll_locked = 1'b0;
        waitrequest = 1'b0;
        c = rand_cfg();
        set_expected(c);
        issue_req(c);
        total++; if (b_write !== 1'b1 || {b_addr, b_wdata} !== exp_w[0]) begin bad++; $display("FAIL to_first_write: got wr=%b addr=%0d data=%h want 1/0/0", b_write, b_addr, b_wdata); end
        n = 0;
        while (n < 20 && !(b_write === 1'b1 && b_addr == 6'd2)) begin @(negedge clk); n++; end
        total++; if (n >= 20) begin bad++; $display("FAIL to_start_seen: got timeout want START write"); end
        // Unlock is seen on the first wait cycle, so lock wait starts one cycle after START.
        k = 0; err_k = -1; busy_before = 1'b0; done_seen = 1'b0;
        while (k < 300 && err_k < 0) begin
            @(negedge clk);
            k++;
            if (b_done === 1'b1) done_seen = 1'b1;
            if (b_error === 1'b1) err_k = k; else busy_before = b_busy;
        end
        total++; if (err_k != LT_B + 2) begin bad++; $display("FAIL timeout_error: got cycle %0d want %0d", err_k, LT_B + 2); end
        total++; if (b_busy !== 1'b0 || busy_before !== 1'b1) begin bad++; $display("FAIL timeout_busy: got busy=%b before=%b want 0/1", b_busy, busy_before); end
        total++; if (done_seen !== 1'b0 || b_done !== 1'b0) begin bad++; $display("FAIL timeout_no_done: got %b want 0", done_seen | b_done); end
        @(negedge clk);
        total++; if (b_error !== 1'b0) begin bad++; $display("FAIL error_pulse: got %b want 0", b_error); end
        pll_locked = 1'b1;
    endtask

    task automatic test_reset_mid();
        pll_cfg_t c1, c2;
        int n, base;
        apply_reset();
        pll_locked = 1'b1;
        waitrequest = 1'b0;
        c1 = rand_cfg();
        issue_req(c1);
        n = 0;
        while (n < 20 && !(a_write === 1'b1 && a_addr == 6'd7)) begin @(negedge clk); n++; end
        total++; if (n >= 20) begin bad++; $display("FAIL mid_k_seen: got timeout want K write"); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({a_busy, a_done, a_error, a_write} !== 4'b0 || a_addr !== 6'd0 || a_wdata !== 32'd0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got busy=%b done=%b err=%b wr=%b addr=%0d data=%h want all 0",
                     a_busy, a_done, a_error, a_write, a_addr, a_wdata);
        end
        c2 = rand_cfg();
        set_expected(c2);
        base = wq_a.size();
        issue_req(c2);
        total++; if (a_write !== 1'b1 || a_addr !== 6'd0) begin bad++; $display("FAIL mid_restart_mode: got wr=%b addr=%0d want 1/0", a_write, a_addr); end
        n = 0;
        while (n < 300 && a_done !== 1'b1) begin @(negedge clk); n++; end
        total++; if (a_done !== 1'b1) begin bad++; $display("FAIL mid_restart_done: got %b want 1", a_done); end
        total++; if (wq_a.size() != base + 6) begin bad++; $display("FAIL mid_count: got %0d want 6", wq_a.size() - base); end
        for (int i = 0; i < 6; i++) begin
            if (wq_a.size() > base + i) begin
                total++;
                if (wq_a[base + i] !== exp_w[i]) begin bad++; $display("FAIL mid_accept%0d: got %h want %h", i, wq_a[base + i], exp_w[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_random_stall();
        test_lock_drop();
        test_lock_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
